// File: rtl/fb_scanout.sv
// fb_scanout: look-ahead framebuffer reader, integer upscaler and palette
// lookup feeding the hdmi rgb input. Define FB_SCANOUT_CURSOR_EN for a crosshair.
module fb_scanout #(
  parameter int          WIDTH        = 1280,
  parameter int          HEIGHT       = 720,
  parameter int          SCALE        = 1,
  parameter int          DATA_BITS    = 4,
  parameter int          READ_LATENCY = 2,
  parameter int          CX_BITS      = 11,
  parameter int          CY_BITS      = 10,
  parameter int          ADDR_BITS    = 20,
  parameter logic [23:0] BORDER_RGB   = 24'h000000
) (
  input  logic                 clk_pixel,
  input  logic                 reset,
  input  logic [CX_BITS-1:0]   cx,
  input  logic [CY_BITS-1:0]   cy,
  input  logic [CX_BITS-1:0]   frame_width,
  input  logic [CY_BITS-1:0]   frame_height,
  output logic                 read_en,
  output logic [ADDR_BITS-1:0] read_addr,
  input  logic [DATA_BITS-1:0] read_data,
  input  logic                 pal_we,
  input  logic [DATA_BITS-1:0] pal_addr,
  input  logic [23:0]          pal_wdata,
  output logic [23:0]          rgb
);

  localparam int FB_W  = WIDTH / SCALE;
  localparam int PAL_N = 2 ** DATA_BITS;
  localparam int SB    = (SCALE > 1) ? $clog2(SCALE) : 1;
  localparam int XW    = CX_BITS + 1;
  localparam int YW    = CY_BITS + 1;

  typedef logic [23:0] pal_t [PAL_N];

  function automatic pal_t f_grey();
    pal_t p;
    for (int i = 0; i < PAL_N; i++) begin
      p[i] = {3{8'(i * 255 / (PAL_N - 1))}};
    end
    return p;
  endfunction

  localparam pal_t GREY = f_grey();

  // look-ahead beam position, widened so cx+latency cannot overflow
  logic [XW-1:0] w_lx_raw;
  logic [XW-1:0] w_lx;
  logic [YW-1:0] w_cy1;
  logic [YW-1:0] w_ly;
  logic          w_wrap;
  logic          w_in;

  assign w_lx_raw = {1'b0, cx} + XW'(READ_LATENCY);
  assign w_wrap   = w_lx_raw >= {1'b0, frame_width};
  assign w_lx     = w_wrap ? w_lx_raw - {1'b0, frame_width}
                           : w_lx_raw;
  assign w_cy1    = {1'b0, cy} + YW'(1);
  assign w_ly     = !w_wrap ? {1'b0, cy}
                  : (w_cy1 == {1'b0, frame_height}) ? '0
                  : w_cy1;
  assign w_in     = (w_lx < XW'(WIDTH)) && (w_ly < YW'(HEIGHT));

  // incremental address counters; they resync at column 0 and line 0
  logic [SB-1:0]        r_csub;
  logic [SB-1:0]        w_csub;
  logic [SB-1:0]        r_rsub;
  logic [SB-1:0]        w_rsub;
  logic [ADDR_BITS-1:0] r_col;
  logic [ADDR_BITS-1:0] w_col;
  logic [ADDR_BITS-1:0] r_row;
  logic [ADDR_BITS-1:0] w_row;
  logic [YW-1:0]        r_ly_prev;
  logic [ADDR_BITS-1:0] w_addr;

  // next column/row position of the look-ahead coordinate
  always_comb begin
    w_csub = r_csub;
    w_col  = r_col;
    w_rsub = r_rsub;
    w_row  = r_row;
    if (w_lx == '0) begin
      w_csub = '0;
      w_col  = '0;
    end else if (r_csub == SB'(SCALE - 1)) begin
      w_csub = '0;
      w_col  = r_col + ADDR_BITS'(1);
    end else begin
      w_csub = r_csub + SB'(1);
    end
    if (w_ly == '0) begin
      w_rsub = '0;
      w_row  = '0;
    end else if (w_ly != r_ly_prev) begin
      if (r_rsub == SB'(SCALE - 1)) begin
        w_rsub = '0;
        w_row  = r_row + ADDR_BITS'(FB_W);
      end else begin
        w_rsub = r_rsub + SB'(1);
      end
    end
  end

  assign w_addr = w_row + w_col;

  // counters track the beam through reset so a mid-frame reset keeps sync
  always_ff @(posedge clk_pixel) begin
    r_csub    <= w_csub;
    r_col     <= w_col;
    r_rsub    <= w_rsub;
    r_row     <= w_row;
    r_ly_prev <= w_ly;
  end

  logic                 r_ren;
  logic [ADDR_BITS-1:0] r_raddr;

  // registered read request; address holds outside the active area
  always_ff @(posedge clk_pixel) begin
    if (reset) begin
      r_ren   <= 1'b0;
      r_raddr <= '0;
    end else begin
      r_ren <= w_in;
      if (w_in) r_raddr <= w_addr;
    end
  end

  logic [READ_LATENCY-1:0] r_act;

  // active flag delayed to line up with read_data
  always_ff @(posedge clk_pixel) begin
    if (reset) r_act <= '0;
    else       r_act <= (r_act << 1) | READ_LATENCY'(w_in);
  end

  // palette stored as difference from the grey ramp: all-zero flops at
  // power-up mean the ramp, and reset never touches the entries
  logic [23:0] r_delta [PAL_N];
  logic [23:0] w_pal;
  logic [23:0] w_pix;

  // palette write port
  always_ff @(posedge clk_pixel) begin
    if (pal_we) r_delta[pal_addr] <= pal_wdata ^ GREY[pal_addr];
  end

  assign w_pal = r_delta[read_data] ^ GREY[read_data];

`ifdef FB_SCANOUT_CURSOR_EN
  localparam int HX = WIDTH / 2;
  localparam int HY = HEIGHT / 2;

  logic [READ_LATENCY-1:0] r_cur;
  logic                    w_cur;
  int                      w_dx;
  int                      w_dy;

  // crosshair coverage of the look-ahead pixel
  always_comb begin
    w_dx  = int'(w_lx) - HX;
    w_dy  = int'(w_ly) - HY;
    w_cur = ((w_dx == 0) && (w_dy >= -8) && (w_dy <= 8)) ||
            ((w_dy == 0) && (w_dx >= -8) && (w_dx <= 8));
  end

  // crosshair flag travels with the active flag
  always_ff @(posedge clk_pixel) begin
    if (reset) r_cur <= '0;
    else       r_cur <= (r_cur << 1) | READ_LATENCY'(w_cur);
  end

  assign w_pix = r_cur[READ_LATENCY-1] ? ~w_pal : w_pal;
`else
  assign w_pix = w_pal;
`endif

  logic [23:0] r_rgb;

  // registered colour output
  always_ff @(posedge clk_pixel) begin
    if (reset)                       r_rgb <= BORDER_RGB;
    else if (r_act[READ_LATENCY-1])  r_rgb <= w_pix;
    else                             r_rgb <= BORDER_RGB;
  end

  assign read_en   = r_ren;
  assign read_addr = r_raddr;
  assign rgb       = r_rgb;

endmodule
